// File: rtl/registers_bank_mp_pkg.sv
// Shared defaults and dump-engine state encoding for the multi-port register bank.
package registers_bank_mp_pkg;

  // Default parameter values used by the bank and its dump engine.
  localparam int DEFAULT_REGISTERS_BANK_SIZE = 32;
  localparam int DEFAULT_REGISTERS_SIZE      = 32;
  localparam int DEFAULT_NUM_READ_PORTS      = 2;
  localparam int DEFAULT_NUM_WRITE_PORTS     = 1;
  localparam int DEFAULT_HARDWIRED_ZERO      = 1;
  localparam int DEFAULT_BYPASS_ENABLE       = 1;

  // Dump engine states; encodings are visible to the debug unit.
  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_SEND = 2'b01,
    DUMP_DONE = 2'b10
  } dump_state_e;

endpackage

// File: rtl/registers_bank_dump_fsm.sv
// Sequential dump engine: walks every register index with a valid/ready
// handshake and pulses done for one cycle after the last accepted beat.
// Only the index is produced here; the bank muxes the register data.
module registers_bank_dump_fsm
  import registers_bank_mp_pkg::*;
#(
  parameter int  REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  localparam int AW                  = $clog2(REGISTERS_BANK_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_index,
  output logic          o_done
);

  localparam logic [AW-1:0] LAST_INDEX = AW'(REGISTERS_BANK_SIZE - 1);
  localparam logic [AW-1:0] INDEX_ONE  = AW'(1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic          valid_q, valid_d;
  logic          done_q,  done_d;

  // State, index and handshake flags; reset aborts a dump with no done pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      index_q <= {AW{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next state and index; start is only honoured in IDLE, index never wraps.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      DUMP_IDLE: begin
        if (i_start) begin
          state_d = DUMP_SEND;
          index_d = {AW{1'b0}};
        end else begin
          state_d = DUMP_IDLE;
          index_d = {AW{1'b0}};
        end
      end
      DUMP_SEND: begin
        if (valid_q && i_ready) begin
          if (index_q == LAST_INDEX) begin
            state_d = DUMP_DONE;
            index_d = index_q;
          end else begin
            state_d = DUMP_SEND;
            index_d = index_q + INDEX_ONE;
          end
        end else begin
          state_d = DUMP_SEND;
          index_d = index_q;
        end
      end
      DUMP_DONE: begin
        state_d = DUMP_IDLE;
        index_d = {AW{1'b0}};
      end
      default: begin
        state_d = DUMP_IDLE;
        index_d = {AW{1'b0}};
      end
    endcase
    valid_d = (state_d == DUMP_SEND);
    done_d  = (state_d == DUMP_DONE);
  end

  assign o_valid = valid_q;
  assign o_index = index_q;
  assign o_done  = done_q;

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register bank: NR combinational read ports, NW synchronous write
// ports (highest index wins on a shared address), optional same-cycle bypass,
// optional hardwired zero register, flat debug view and a handshaked dump.
module registers_bank_mp
  import registers_bank_mp_pkg::*;
#(
  parameter int  REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  parameter int  REGISTERS_SIZE      = DEFAULT_REGISTERS_SIZE,
  parameter int  NUM_READ_PORTS      = DEFAULT_NUM_READ_PORTS,
  parameter int  NUM_WRITE_PORTS     = DEFAULT_NUM_WRITE_PORTS,
  parameter int  HARDWIRED_ZERO      = DEFAULT_HARDWIRED_ZERO,
  parameter int  BYPASS_ENABLE       = DEFAULT_BYPASS_ENABLE,
  localparam int AW                  = $clog2(REGISTERS_BANK_SIZE),
  localparam int W                   = REGISTERS_SIZE
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_flush,
  input  logic [NUM_WRITE_PORTS-1:0]        i_write_enable,
  input  logic [NUM_WRITE_PORTS*AW-1:0]     i_addr_wr,
  input  logic [NUM_WRITE_PORTS*W-1:0]      i_bus_wr,
  input  logic [NUM_READ_PORTS*AW-1:0]      i_addr_rd,
  output logic [NUM_READ_PORTS*W-1:0]       o_bus_rd,
  input  logic                              i_dump_start,
  input  logic                              i_dump_ready,
  output logic                              o_dump_valid,
  output logic [AW-1:0]                     o_dump_addr,
  output logic [W-1:0]                      o_dump_data,
  output logic                              o_dump_done,
  output logic [REGISTERS_BANK_SIZE*W-1:0]  o_bus_debug
);

  localparam int N  = REGISTERS_BANK_SIZE;
  localparam int NR = NUM_READ_PORTS;
  localparam int NW = NUM_WRITE_PORTS;

  logic [W-1:0]  regs_q [N];
  logic [W-1:0]  regs_d [N];
  logic [AW-1:0] wr_addr [NW];
  logic [W-1:0]  wr_data [NW];
  logic [AW-1:0] dump_index;

  // Unpack the flat write buses into per-port views.
  for (genvar k = 0; k < NW; k++) begin : g_wr_unpack
    assign wr_addr[k] = i_addr_wr[k*AW +: AW];
    assign wr_data[k] = i_bus_wr[k*W +: W];
  end

  // Next register contents: flush clears everything; otherwise ports apply in
  // ascending order so the highest enabled port owns a shared address.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      regs_d[j] = regs_q[j];
    end
    if (i_flush) begin
      for (int j = 0; j < N; j++) begin
        regs_d[j] = {W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        for (int j = 0; j < N; j++) begin
          regs_d[j] = (i_write_enable[k] && (wr_addr[k] == AW'(j))) ? wr_data[k] : regs_d[j];
        end
      end
    end
    regs_d[0] = (HARDWIRED_ZERO != 0) ? {W{1'b0}} : regs_d[0];
  end

  // Register storage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int j = 0; j < N; j++) begin
        regs_q[j] <= {W{1'b0}};
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        regs_q[j] <= regs_d[j];
      end
    end
  end

  // One combinational read path per port.
  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [AW-1:0] rd_addr;
    logic          byp_hit;
    logic [W-1:0]  byp_data;
    logic [W-1:0]  rd_data;

    assign rd_addr = i_addr_rd[r*AW +: AW];

    // Winning same-cycle write for this port's address (last match wins).
    always_comb begin
      byp_hit  = 1'b0;
      byp_data = {W{1'b0}};
      for (int k = 0; k < NW; k++) begin
        byp_data = (i_write_enable[k] && (wr_addr[k] == rd_addr)) ? wr_data[k] : byp_data;
        byp_hit  = byp_hit | (i_write_enable[k] && (wr_addr[k] == rd_addr));
      end
    end

    // Read mux: zero register first, then bypass (zeroed by flush), then storage.
    always_comb begin
      if ((HARDWIRED_ZERO != 0) && (rd_addr == {AW{1'b0}})) begin
        rd_data = {W{1'b0}};
      end else if ((BYPASS_ENABLE != 0) && byp_hit) begin
        rd_data = i_flush ? {W{1'b0}} : byp_data;
      end else begin
        rd_data = regs_q[rd_addr];
      end
    end

    assign o_bus_rd[r*W +: W] = rd_data;
  end

  // Flat debug view always reflects stored values.
  for (genvar j = 0; j < N; j++) begin : g_debug
    assign o_bus_debug[j*W +: W] = regs_q[j];
  end

  registers_bank_dump_fsm #(
    .REGISTERS_BANK_SIZE (N)
  ) u_dump_fsm (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_dump_start),
    .i_ready (i_dump_ready),
    .o_valid (o_dump_valid),
    .o_index (dump_index),
    .o_done  (o_dump_done)
  );

  // Dump data is read live, so a flush mid-dump shows up in later beats.
  assign o_dump_addr = dump_index;
  assign o_dump_data = regs_q[dump_index];

endmodule

// File: tb/tb_registers_bank_mp.sv
// Scoreboard bench for registers_bank_mp: a bypassing instance and a
// non-bypassing twin share write/read stimulus; the dump runs on the first.
`timescale 1ns/1ps
module tb_registers_bank_mp;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  localparam int K_RDA   = 0;
  localparam int K_RDB   = 1;
  localparam int K_DBG   = 2;
  localparam int K_DBGZ  = 3;
  localparam int K_VALID = 4;
  localparam int K_DONE  = 5;
  localparam int K_ADDR  = 6;
  localparam int K_DDATA = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [NW-1:0]   we;
  logic [NW*AW-1:0] awr;
  logic [NW*W-1:0] wbus;
  logic [NR*AW-1:0] ard;
  logic [NR*W-1:0] rd_a, rd_b;
  logic            dstart, dready;
  logic            dump_valid, dump_done;
  logic [AW-1:0]   dump_addr;
  logic [W-1:0]    dump_data;
  logic [N*W-1:0]  dbg_a, dbg_b;
  logic            nb_valid, nb_done;
  logic [AW-1:0]   nb_addr;
  logic [W-1:0]    nb_data;

  always #5 clk = ~clk;

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .NUM_READ_PORTS(NR),
    .NUM_WRITE_PORTS(NW), .HARDWIRED_ZERO(1), .BYPASS_ENABLE(1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_write_enable(we),
    .i_addr_wr(awr), .i_bus_wr(wbus), .i_addr_rd(ard), .o_bus_rd(rd_a),
    .i_dump_start(dstart), .i_dump_ready(dready), .o_dump_valid(dump_valid),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_done(dump_done),
    .o_bus_debug(dbg_a)
  );

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .NUM_READ_PORTS(NR),
    .NUM_WRITE_PORTS(NW), .HARDWIRED_ZERO(1), .BYPASS_ENABLE(0)
  ) dut_nb (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_write_enable(we),
    .i_addr_wr(awr), .i_bus_wr(wbus), .i_addr_rd(ard), .o_bus_rd(rd_b),
    .i_dump_start(1'b0), .i_dump_ready(1'b0), .o_dump_valid(nb_valid),
    .o_dump_addr(nb_addr), .o_dump_data(nb_data), .o_dump_done(nb_done),
    .o_bus_debug(dbg_b)
  );

  typedef struct {
    int          kind;
    int          idx;
    logic [W-1:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } beat_t;

  chk_t  chk_q[$];
  beat_t beat_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;
  int    done_cnt = 0;

  function automatic logic [W-1:0] actual(int kind, int idx);
    case (kind)
      K_RDA:   return rd_a[idx*W +: W];
      K_RDB:   return rd_b[idx*W +: W];
      K_DBG:   return dbg_a[idx*W +: W];
      K_DBGZ:  return {{(W-1){1'b0}}, (|dbg_a) | (|dbg_b)};
      K_VALID: return {{(W-1){1'b0}}, dump_valid};
      K_DONE:  return {{(W-1){1'b0}}, dump_done};
      K_ADDR:  return {{(W-AW){1'b0}}, dump_addr};
      K_DDATA: return dump_data;
      default: return {W{1'b1}};
    endcase
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_v(int kind, int idx, logic [W-1:0] exp, string name);
    chk_t c;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(int p, logic en, logic [AW-1:0] a, logic [W-1:0] d);
    we[p] = en;
    awr[p*AW +: AW] = a;
    wbus[p*W +: W] = d;
  endtask

  task automatic drive_rd(int p, logic [AW-1:0] a);
    ard[p*AW +: AW] = a;
  endtask

  // Monitor: drains pending expectations and checks dump beats away from the edge.
  always @(negedge clk) begin : mon
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check(c.name, actual(c.kind, c.idx), c.exp);
    end
    if (dump_valid) begin
      if (beat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dump_extra_beat actual_addr=%0d required=no_beat", dump_addr);
      end else begin
        check("dump_addr", {{(W-AW){1'b0}}, dump_addr}, {{(W-AW){1'b0}}, beat_q[0].addr});
        check("dump_data", dump_data, beat_q[0].data);
        if (dready) begin
          void'(beat_q.pop_front());
          beats++;
        end
      end
    end
    if (dump_done) done_cnt++;
  end

  initial begin
    rst = 1'b1; flush = 1'b0; we = '0; awr = '0; wbus = '0; ard = '0;
    dstart = 1'b0; dready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    expect_v(K_DBGZ, 0, 32'h0, "reset_debug_zero");
    expect_v(K_VALID, 0, 32'h0, "reset_valid");
    expect_v(K_DONE, 0, 32'h0, "reset_done");
    expect_v(K_ADDR, 0, 32'h0, "reset_addr");
    expect_v(K_DDATA, 0, 32'h0, "reset_data");
    step();
    rst = 1'b0;

    // Single write to r5
    drive_wr(0, 1'b1, 5'd5, 32'h1234); drive_rd(0, 5'd5); drive_rd(1, 5'd0);
    expect_v(K_RDA, 0, 32'h1234, "byp_r5");
    expect_v(K_RDB, 0, 32'h0, "nobyp_r5_old");
    step();
    we = '0;
    expect_v(K_RDA, 0, 32'h1234, "r5_next_a");
    expect_v(K_RDB, 0, 32'h1234, "r5_next_b");
    step();

    // Write conflict on r7: port 1 wins
    drive_wr(0, 1'b1, 5'd7, 32'hAAAA); drive_wr(1, 1'b1, 7, 32'hBBBB); drive_rd(0, 5'd7);
    expect_v(K_RDA, 0, 32'hBBBB, "conflict_byp");
    expect_v(K_RDB, 0, 32'h0, "conflict_nobyp_old");
    step();
    we = '0;
    expect_v(K_RDA, 0, 32'hBBBB, "conflict_r7_a");
    expect_v(K_RDB, 0, 32'hBBBB, "conflict_r7_b");
    expect_v(K_DBG, 7, 32'hBBBB, "conflict_dbg7");
    step();

    // Zero register ignores writes, even through bypass
    drive_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF); drive_rd(0, 5'd0);
    expect_v(K_RDA, 0, 32'h0, "zero_byp");
    expect_v(K_RDB, 0, 32'h0, "zero_nobyp");
    step();
    we = '0;
    expect_v(K_RDA, 0, 32'h0, "zero_next");
    expect_v(K_DBG, 0, 32'h0, "zero_dbg");
    step();

    // Bypass vs stored value on r3
    drive_wr(1, 1'b1, 5'd3, 32'h11);
    step();
    we = '0;
    drive_wr(0, 1'b1, 5'd3, 32'h55); drive_rd(0, 5'd3); drive_rd(1, 5'd5);
    expect_v(K_RDA, 0, 32'h55, "byp_r3_new");
    expect_v(K_RDB, 0, 32'h11, "nobyp_r3_old");
    expect_v(K_RDA, 1, 32'h1234, "other_port_a");
    expect_v(K_RDB, 1, 32'h1234, "other_port_b");
    step();
    we = '0;
    expect_v(K_RDA, 0, 32'h55, "r3_next_a");
    expect_v(K_RDB, 0, 32'h55, "r3_next_b");
    step();

    // Flush beats a same-cycle write to r9
    drive_wr(0, 1'b1, 5'd9, 32'h66);
    step();
    flush = 1'b1;
    drive_wr(0, 1'b1, 5'd9, 32'h77); drive_rd(0, 5'd9); drive_rd(1, 5'd5);
    expect_v(K_RDA, 0, 32'h0, "flush_byp_r9");
    expect_v(K_RDB, 0, 32'h66, "flush_nobyp_r9");
    expect_v(K_RDA, 1, 32'h1234, "flush_stored_r5");
    step();
    flush = 1'b0; we = '0;
    expect_v(K_RDA, 0, 32'h0, "after_flush_r9_a");
    expect_v(K_RDB, 0, 32'h0, "after_flush_r9_b");
    expect_v(K_RDA, 1, 32'h0, "after_flush_r5");
    expect_v(K_DBGZ, 0, 32'h0, "after_flush_all_zero");
    step();

    // Preload r[i] = i*3 two registers per cycle
    for (int c = 0; c < N/2; c++) begin
      drive_wr(0, 1'b1, AW'(2*c), 32'(6*c));
      drive_wr(1, 1'b1, AW'(2*c+1), 32'(6*c+3));
      step();
    end
    we = '0;
    expect_v(K_DBG, 31, 32'd93, "preload_r31");
    expect_v(K_DBG, 0, 32'd0, "preload_r0");
    step();

    // Full dump with random ready
    for (int i = 0; i < N; i++) begin
      beat_t b;
      b.addr = AW'(i);
      b.data = 32'(i*3);
      beat_q.push_back(b);
    end
    beats = 0;
    dstart = 1'b1;
    step();
    dstart = 1'b0;
    for (int cyc = 0; cyc < 2000 && done_cnt == 0; cyc++) begin
      dready = 1'($urandom_range(0, 1));
      step();
    end
    dready = 1'b0;
    check("dump_done_seen", 32'(done_cnt), 32'd1);
    check("dump_beats", 32'(beats), 32'd32);
    check("dump_queue_left", 32'(beat_q.size()), 32'd0);
    repeat (4) step();
    check("dump_done_single", 32'(done_cnt), 32'd1);
    expect_v(K_VALID, 0, 32'h0, "dump_idle_valid");
    step();

    // Second dump, reset after ten accepted beats
    for (int i = 0; i < N; i++) begin
      beat_t b;
      b.addr = AW'(i);
      b.data = 32'(i*3);
      beat_q.push_back(b);
    end
    beats = 0;
    dstart = 1'b1;
    step();
    dstart = 1'b0;
    for (int cyc = 0; cyc < 2000 && beats < 10; cyc++) begin
      dready = 1'($urandom_range(0, 1));
      step();
    end
    dready = 1'b0;
    check("reset_at_beat10", 32'(beats), 32'd10);
    #1;
    rst = 1'b1;
    beat_q.delete();
    expect_v(K_VALID, 0, 32'h0, "midreset_valid");
    expect_v(K_DONE, 0, 32'h0, "midreset_done");
    expect_v(K_ADDR, 0, 32'h0, "midreset_addr");
    expect_v(K_DBGZ, 0, 32'h0, "midreset_debug_zero");
    step();
    step();
    rst = 1'b0;
    dready = 1'b1;
    repeat (5) step();
    check("no_done_after_reset", 32'(done_cnt), 32'd1);
    expect_v(K_VALID, 0, 32'h0, "post_reset_idle");
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
